io_reg_bank: RTL



---
 rtl/io_reg_bank_pkg.sv | 27 ++
 rtl/io_filter_channel.sv | 85 ++++++++
 rtl/io_reg_bank.sv | 64 ++++++
 3 files changed

// File: rtl/io_reg_bank_pkg.sv
// Shared definitions for the registered I/O cells: default sizes, init fills,
// filter decision encoding and the counter width helper.
package io_reg_bank_pkg;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_FILTER_COUNT = 3;

  // Per-bit reset fills; widened to WIDTH by the user of the package.
  localparam logic DEF_OUT_BIT = 1'b0;  // pad driven low
  localparam logic DEF_TRI_BIT = 1'b1;  // pad released (high-Z)
  localparam logic DEF_IN_BIT  = 1'b1;  // inputs assumed pulled up

  // Action taken by a channel's glitch filter on one clock edge.
  typedef enum logic [1:0] {
    FLT_HOLD,    // sample not qualified (inCE low)
    FLT_CLEAR,   // sample matches accepted level
    FLT_COUNT,   // sample differs, count not yet complete
    FLT_ACCEPT   // sample differs and count complete: take new level
  } flt_act_e;

  // Counter width for a filter of n samples, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_filter_channel.sv
// One input channel: synchroniser, consecutive-sample glitch filter and
// registered rise/fall detection of the accepted level.
module io_filter_channel
  import io_reg_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_COUNT = DEF_FILTER_COUNT,
  parameter logic        IN_INIT      = DEF_IN_BIT
) (
  input  logic clk,
  input  logic nReset,
  input  logic inCE,
  input  logic padIn,
  output logic dataIn,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CW       = cnt_width(FILTER_COUNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_COUNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_data;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  flt_act_e               w_act;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign dataIn = r_data;
  assign rise   = r_rise;
  assign fall   = r_fall;

  // Synchroniser shift chain, clocked every edge regardless of inCE.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_sync <= {SYNC_STAGES{IN_INIT}};
    end else begin
      r_sync[0] <= padIn;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Decide what the filter does with the current synchronised sample.
  always_comb begin
    w_act = FLT_HOLD;
    if (inCE) begin
      if (w_s == r_data) begin
        w_act = FLT_CLEAR;
      end else if (r_cnt == CNT_LAST) begin
        w_act = FLT_ACCEPT;
      end else begin
        w_act = FLT_COUNT;
      end
    end
  end

  // Filter counter, accepted level and single-cycle edge pulses.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt  <= '0;
      r_data <= IN_INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (w_act)
        FLT_CLEAR: r_cnt <= '0;
        FLT_COUNT: r_cnt <= r_cnt + CW'(1);
        FLT_ACCEPT: begin
          r_cnt  <= '0;
          r_data <= w_s;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/io_reg_bank.sv
// Multi-channel registered I/O bank: per-channel write-enabled output and
// tristate registers, plus a filtered, edge-detected input per channel.
module io_reg_bank
  import io_reg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter int unsigned      SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned      FILTER_COUNT = DEF_FILTER_COUNT,
  parameter logic [WIDTH-1:0] OUT_INIT     = {WIDTH{DEF_OUT_BIT}},
  parameter logic [WIDTH-1:0] TRI_INIT     = {WIDTH{DEF_TRI_BIT}},
  parameter logic [WIDTH-1:0] IN_INIT      = {WIDTH{DEF_IN_BIT}}
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] outWE,
  input  logic [WIDTH-1:0] dataOut,
  input  logic [WIDTH-1:0] tristate,
  input  logic             inCE,
  output logic [WIDTH-1:0] padOut,
  output logic [WIDTH-1:0] padTristate,
  input  logic [WIDTH-1:0] padIn,
  output logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_tri;

  assign padOut      = r_out;
  assign padTristate = r_tri;

  // Output data and tristate registers, each bit written only by its strobe.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_out <= OUT_INIT;
      r_tri <= TRI_INIT;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (outWE[i]) begin
          r_out[i] <= dataOut[i];
          r_tri[i] <= tristate[i];
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_in
    io_filter_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_COUNT (FILTER_COUNT),
      .IN_INIT      (IN_INIT[g])
    ) u_chan (
      .clk    (clk),
      .nReset (nReset),
      .inCE   (inCE),
      .padIn  (padIn[g]),
      .dataIn (dataIn[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule
